// File: rtl/fracmul_pkg.sv
// Shared types and width helpers for the sequential fraction multiplier family.
package fracmul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Product width PW for an n-bit Q1.(n-1) operand pair.
  function automatic int prod_w(input int n);
    return 2 * n - 1;
  endfunction

  // Step counter width CW; counts 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Largest positive two's-complement value of width w (0 followed by w-1 ones).
  function automatic logic [63:0] sat_pos(input int w);
    return 64'hFFFF_FFFF_FFFF_FFFF >> (65 - w);
  endfunction

endpackage

// File: rtl/fracmul_round_sat.sv
// Rounds a Q1.(2N-2) product half-up to Q1.(N-1), saturating positive wrap.
module fracmul_round_sat
  import fracmul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] prod_hi,
  input  logic         rnd_bit,
  output logic [N-1:0] rnd
);

  localparam logic [N-1:0] SAT_RND = N'(sat_pos(N));

  logic signed [N:0] sum;

  // Only a positive value can overflow when adding the round bit.
  always_comb begin
    sum = $signed({prod_hi[N-1], prod_hi}) + $signed({{N{1'b0}}, rnd_bit});
    rnd = sum[N-1:0];
    if (sum[N] != sum[N-1]) rnd = SAT_RND;
  end

endmodule

// File: rtl/fraction_multiplier_n.sv
// Sequential add/sub-and-shift two's-complement fraction multiplier, one step per
// multiplier bit, with a rounded/saturated N-bit result.
module fraction_multiplier_n
  import fracmul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           St,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic [2*N-2:0] Product,
  output logic [N-1:0]   ProductRnd,
  output logic           Ovf,
  output logic           Busy,
  output logic           Done
);

  localparam int PW = prod_w(N);
  localparam int CW = cnt_w(N);
  localparam logic [PW-1:0] SAT_PROD = PW'(sat_pos(PW));
  localparam logic [N-1:0]  MIN_OP   = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t              state_q, state_d;
  logic signed [N-1:0] a_q, a_d;
  logic signed [N-1:0] mcand_q, mcand_d;
  logic [N-1:0]        b_q, b_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic [PW-1:0]       product_q, product_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic signed [N:0]   mc_ext, addend, sum;
  logic                last_step;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    product_d  = product_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = done_q;

    // The sign-bit step subtracts, which makes a negative multiplier work.
    last_step = (cnt_q == LAST_CNT);
    mc_ext    = {mcand_q[N-1], mcand_q};
    addend    = '0;
    if (b_q[0]) addend = last_step ? -mc_ext : mc_ext;
    sum = {a_q[N-1], a_q} + addend;

    unique case (state_q)
      IDLE: begin
        if (St) begin
          a_d        = '0;
          b_d        = Mplier;
          mcand_d    = Mcand;
          cnt_d      = '0;
          ovf_pend_d = (Mplier == MIN_OP) && (Mcand == MIN_OP);
          busy_d     = 1'b1;
          done_d     = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d   = sum[N:1];
        b_d   = {sum[0], b_q[N-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          product_d = ovf_pend_q ? SAT_PROD : {sum[N-1:0], b_q[N-1:1]};
          ovf_d     = ovf_pend_q;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      product_q  <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      product_q  <= product_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    mcand_q <= mcand_d;
  end

  fracmul_round_sat #(.N(N)) u_round_sat (
    .prod_hi (product_q[PW-1:N-1]),
    .rnd_bit (product_q[N-2]),
    .rnd     (ProductRnd)
  );

  assign Product = product_q;
  assign Ovf     = ovf_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_fraction_multiplier_n.sv
// Bench for fraction_multiplier_n at N=4, 8 and 16 against an arithmetic reference.
module tb_fraction_multiplier_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st4 = 1'b0, st8 = 1'b0, st16 = 1'b0;
  logic [3:0]  mp4 = '0, mc4 = '0;
  logic [7:0]  mp8 = '0, mc8 = '0;
  logic [15:0] mp16 = '0, mc16 = '0;
  logic [6:0]  prod4;
  logic [14:0] prod8;
  logic [30:0] prod16;
  logic [3:0]  rnd4;
  logic [7:0]  rnd8;
  logic [15:0] rnd16;
  logic ovf4, ovf8, ovf16, busy4, busy8, busy16, done4, done8, done16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fraction_multiplier_n #(.N(4)) u4 (
    .CLK(clk), .RST(rst), .St(st4), .Mplier(mp4), .Mcand(mc4), .Product(prod4),
    .ProductRnd(rnd4), .Ovf(ovf4), .Busy(busy4), .Done(done4));
  fraction_multiplier_n #(.N(8)) u8 (
    .CLK(clk), .RST(rst), .St(st8), .Mplier(mp8), .Mcand(mc8), .Product(prod8),
    .ProductRnd(rnd8), .Ovf(ovf8), .Busy(busy8), .Done(done8));
  fraction_multiplier_n #(.N(16)) u16 (
    .CLK(clk), .RST(rst), .St(st16), .Mplier(mp16), .Mcand(mc16), .Product(prod16),
    .ProductRnd(rnd16), .Ovf(ovf16), .Busy(busy16), .Done(done16));

  function automatic longint sext(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint rd_prod(input int n);
    case (n)
      4:       return sext(longint'(prod4), 7);
      8:       return sext(longint'(prod8), 15);
      default: return sext(longint'(prod16), 31);
    endcase
  endfunction

  function automatic longint rd_rnd(input int n);
    case (n)
      4:       return sext(longint'(rnd4), 4);
      8:       return sext(longint'(rnd8), 8);
      default: return sext(longint'(rnd16), 16);
    endcase
  endfunction

  function automatic logic rd_ovf(input int n);
    case (n)
      4: return ovf4;
      8: return ovf8;
      default: return ovf16;
    endcase
  endfunction

  function automatic logic rd_busy(input int n);
    case (n)
      4: return busy4;
      8: return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic rd_done(input int n);
    case (n)
      4: return done4;
      8: return done8;
      default: return done16;
    endcase
  endfunction

  task automatic drive(input int n, input logic s, input longint mp, input longint mc);
    case (n)
      4:       begin st4 = s;  mp4 = mp[3:0];   mc4 = mc[3:0];   end
      8:       begin st8 = s;  mp8 = mp[7:0];   mc8 = mc[7:0];   end
      default: begin st16 = s; mp16 = mp[15:0]; mc16 = mc[15:0]; end
    endcase
  endtask

  // Exact fraction product scaled by 2^(2n-2); -1 x -1 clamps to the largest positive.
  task automatic model(input int n, input longint mp, input longint mc,
                       output longint p, output longint r, output logic ov);
    longint a, b, lo, hi;
    a  = sext(mp, n);
    b  = sext(mc, n);
    lo = -(longint'(1) << (n - 1));
    hi = (longint'(1) << (n - 1)) - 1;
    ov = (a == lo) && (b == lo);
    p  = ov ? (longint'(1) << (2 * n - 2)) - 1 : a * b;
    r  = (p + (longint'(1) << (n - 2))) >>> (n - 1);
    if (r > hi) r = hi;
  endtask

  // Starts one operation, scrambles the operand inputs after capture, waits for Done
  // and then one more cycle so the unit is back in IDLE.
  task automatic run_op(input int n, input longint mp, input longint mc,
                        output int lat, output int busy_cyc, output logic done_after);
    logic got;
    @(negedge clk);
    drive(n, 1'b1, mp, mc);
    @(posedge clk); #1;
    drive(n, 1'b0, longint'($urandom), longint'($urandom));
    busy_cyc = rd_busy(n) ? 1 : 0;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rd_done(n)) got = 1'b1;
      else if (rd_busy(n)) busy_cyc++;
    end
    if (!got) lat = -1;
    @(posedge clk); #1;
    done_after = rd_done(n);
  endtask

  task automatic test_reset();
    int ns[3] = '{4, 8, 16};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    foreach (ns[k]) begin
      checks++;
      if (rd_prod(ns[k]) !== 0 || rd_rnd(ns[k]) !== 0 || rd_ovf(ns[k]) !== 1'b0 ||
          rd_busy(ns[k]) !== 1'b0 || rd_done(ns[k]) !== 1'b0) begin
        failures++;
        $display("FAIL reset n=%0d prod=%0d rnd=%0d ovf=%b busy=%b done=%b required all 0",
                 ns[k], rd_prod(ns[k]), rd_rnd(ns[k]), rd_ovf(ns[k]), rd_busy(ns[k]), rd_done(ns[k]));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed_n4();
    longint mp[4]   = '{4, 12, 8, 6};
    longint mc[4]   = '{4, 6, 8, 6};
    longint eprod[4] = '{16, -24, 63, 36};
    longint ernd[4]  = '{2, -3, 7, 5};
    logic   eovf[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bc;
    logic da;
    for (int i = 0; i < 4; i++) begin
      run_op(4, mp[i], mc[i], lat, bc, da);
      checks++;
      if (lat != 4 || bc != 4 || da !== 1'b0) begin
        failures++;
        $display("FAIL dir_timing case=%0d lat=%0d busy=%0d done_after=%b required 4 4 0", i, lat, bc, da);
      end
      checks++;
      if (rd_prod(4) !== eprod[i]) begin
        failures++;
        $display("FAIL dir_prod case=%0d got=%0d required=%0d", i, rd_prod(4), eprod[i]);
      end
      checks++;
      if (rd_rnd(4) !== ernd[i] || rd_ovf(4) !== eovf[i]) begin
        failures++;
        $display("FAIL dir_rnd_ovf case=%0d rnd=%0d ovf=%b required %0d %b",
                 i, rd_rnd(4), rd_ovf(4), ernd[i], eovf[i]);
      end
    end
  endtask

  task automatic test_ignore_st();
    int bc, dc;
    logic got;
    @(negedge clk);
    drive(4, 1'b1, 5, 3);
    @(posedge clk); #1;
    bc = busy4 ? 1 : 0;
    dc = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      drive(4, 1'b1, longint'($urandom), longint'($urandom));
      @(posedge clk); #1;
      if (done4) begin dc++; got = 1'b1; end
      else if (busy4) bc++;
    end
    @(negedge clk);
    drive(4, 1'b1, longint'($urandom), longint'($urandom));
    @(posedge clk); #1;
    if (done4) dc++;
    if (busy4) bc++;
    @(negedge clk);
    drive(4, 1'b0, 0, 0);
    repeat (4) begin
      @(posedge clk); #1;
      if (done4) dc++;
      if (busy4) bc++;
    end
    checks++;
    if (dc != 1 || bc != 4) begin
      failures++;
      $display("FAIL ignore_st done_pulses=%0d busy_cycles=%0d required 1 4", dc, bc);
    end
    checks++;
    if (rd_prod(4) !== 15 || rd_rnd(4) !== 2 || ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_st_result prod=%0d rnd=%0d ovf=%b required 15 2 0", rd_prod(4), rd_rnd(4), ovf4);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic da;
    @(negedge clk);
    drive(4, 1'b1, 7, 5);
    @(posedge clk); #1;
    drive(4, 1'b0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (prod4 !== '0 || rnd4 !== '0 || ovf4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid prod=%0d rnd=%0d ovf=%b busy=%b done=%b required all 0",
               prod4, rnd4, ovf4, busy4, done4);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(4, 3, 3, lat, bc, da);
    checks++;
    if (lat != 4 || rd_prod(4) !== 9 || rd_rnd(4) !== 1 || ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL after_reset lat=%0d prod=%0d rnd=%0d ovf=%b required 4 9 1 0",
               lat, rd_prod(4), rd_rnd(4), ovf4);
    end
  endtask

  task automatic test_random(input int n, input int count);
    longint mask, minv, maxv, mp, mc, ep, er;
    logic eo, da;
    int lat, bc;
    mask = (longint'(1) << n) - 1;
    minv = longint'(1) << (n - 1);
    maxv = minv - 1;
    for (int i = 0; i < count + 4; i++) begin
      case (i)
        0: begin mp = minv; mc = minv; end
        1: begin mp = minv; mc = maxv; end
        2: begin mp = maxv; mc = maxv; end
        3: begin mp = minv; mc = 0;    end
        default: begin
          mp = longint'($urandom) & mask;
          mc = longint'($urandom) & mask;
          if ($urandom_range(0, 7) == 0) mp = minv;
        end
      endcase
      model(n, mp, mc, ep, er, eo);
      run_op(n, mp, mc, lat, bc, da);
      checks++;
      if (lat != n || bc != n || da !== 1'b0) begin
        failures++;
        $display("FAIL rnd_timing n=%0d lat=%0d busy=%0d done_after=%b required %0d %0d 0",
                 n, lat, bc, da, n, n);
      end
      checks++;
      if (rd_prod(n) !== ep) begin
        failures++;
        $display("FAIL rnd_prod n=%0d mp=%0h mc=%0h got=%0d required=%0d", n, mp, mc, rd_prod(n), ep);
      end
      checks++;
      if (rd_rnd(n) !== er || rd_ovf(n) !== eo) begin
        failures++;
        $display("FAIL rnd_round n=%0d mp=%0h mc=%0h rnd=%0d ovf=%b required %0d %b",
                 n, mp, mc, rd_rnd(n), rd_ovf(n), er, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_n4();
    test_ignore_st();
    test_reset_mid();
    test_random(4, 20);
    test_random(8, 30);
    test_random(16, 30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
